branch_predictor: RTL

Fetch-side branch target buffer (BTB) with 2-bit saturating direction counters. It looks up the fetch PC and returns a registered taken/target prediction one cycle later, which the pipeline carries alongside the instruction. It is trained by the execute stage's resolved outcome: the same stage that compares the predicted target against the actual next PC and raises the redirect.

---
 rtl/branch_predictor.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side BTB with 2-bit saturating direction counters.
// Registered prediction one cycle after lookup; trained by execute-stage outcomes.
module branch_predictor #(
  parameter int IADDR_SPACE_BITS  = 32,
  parameter int ENTRIES           = 16,
  parameter bit BRANCH_PREDICTION = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_fetch_valid,
  input  logic [IADDR_SPACE_BITS-1:1] i_fetch_pc,
  output logic                        o_pred_taken,
  output logic [IADDR_SPACE_BITS-1:1] o_pred_target,
  input  logic                        i_upd_valid,
  input  logic [IADDR_SPACE_BITS-1:1] i_upd_pc,
  input  logic [IADDR_SPACE_BITS-1:1] i_upd_target,
  input  logic                        i_upd_branch,
  input  logic                        i_upd_jump,
  input  logic                        i_upd_taken
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = IADDR_SPACE_BITS - 1 - IDX_BITS;

  logic [ENTRIES-1:0]          valid;
  logic [1:0]                  ctr        [ENTRIES];
  logic [TAG_BITS-1:0]         tag_mem    [ENTRIES];
  logic [IADDR_SPACE_BITS-1:1] target_mem [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic [TAG_BITS-1:0] upd_tag;
  logic                fetch_hit;
  logic                upd_hit;

  assign fetch_idx = i_fetch_pc[IDX_BITS:1];
  assign fetch_tag = i_fetch_pc[IADDR_SPACE_BITS-1:IDX_BITS+1];
  assign upd_idx   = i_upd_pc[IDX_BITS:1];
  assign upd_tag   = i_upd_pc[IADDR_SPACE_BITS-1:IDX_BITS+1];
  assign fetch_hit = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign upd_hit   = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  logic       wr_entry;
  logic       wr_ctr;
  logic       clr_valid;
  logic [1:0] new_ctr;

  // Jump wins over branch when both flags are set.
  always_comb begin
    wr_entry  = 1'b0;
    wr_ctr    = 1'b0;
    clr_valid = 1'b0;
    new_ctr   = ctr[upd_idx];
    if (i_upd_valid && BRANCH_PREDICTION) begin
      if (i_upd_jump) begin
        wr_entry = 1'b1;
        wr_ctr   = 1'b1;
        new_ctr  = 2'b11;
      end else if (i_upd_branch && i_upd_taken) begin
        wr_entry = 1'b1;
        wr_ctr   = 1'b1;
        if (!upd_hit)
          new_ctr = 2'b10;
        else if (ctr[upd_idx] != 2'b11)
          new_ctr = ctr[upd_idx] + 2'd1;
      end else if (i_upd_branch) begin
        if (upd_hit) begin
          wr_ctr = 1'b1;
          if (ctr[upd_idx] != 2'b00)
            new_ctr = ctr[upd_idx] - 2'd1;
        end
      end else if (upd_hit) begin
        clr_valid = 1'b1;
      end
    end
  end

  // Lookup reads pre-update contents; writes land at the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid         <= '0;
      o_pred_taken  <= 1'b0;
      o_pred_target <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr[i] <= 2'b01;
    end else begin
      if (wr_entry)
        valid[upd_idx] <= 1'b1;
      else if (clr_valid)
        valid[upd_idx] <= 1'b0;
      if (wr_ctr)
        ctr[upd_idx] <= new_ctr;
      o_pred_taken  <= i_fetch_valid & ~i_flush & fetch_hit & ctr[fetch_idx][1] & BRANCH_PREDICTION;
      o_pred_target <= fetch_hit ? target_mem[fetch_idx] : i_fetch_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_entry) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= i_upd_target;
    end
  end

endmodule
